// File: rtl/spi_bridge_defs.sv
// Shared definitions for the SPI-to-register bridge.
// Frame layout constants and FSM state encodings.
package spi_bridge_defs;

  localparam int CMD_WR_BIT    = 7;
  localparam int CMD_BURST_BIT = 6;
  localparam int CMD_BITS      = 8;
  localparam int ADDR_BITS     = 8;
  localparam int CNT_W         = 5;

  typedef enum logic [2:0] {
    ST_WAIT_CS,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA
  } state_t;

  function automatic logic in_frame(state_t s);
    return s inside {ST_CMD, ST_ADDR, ST_DATA};
  endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Register-bus port between the SPI bridge and the config block.
// The bridge is master; the register file is slave.
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic              reg_ce;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;

  modport master (
    output reg_ce,
    output reg_we,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_ce,
    input  reg_we,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata
  );

endinterface

// File: rtl/spi_pin_sync.sv
// Synchroniser chain for one async SPI pin, with edge pulses.
// Chain and edge history reset low so reset never fakes a CS fall.
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge CLK) begin
    if (rst) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[STAGES-2:0], pin};
      prev <= sr[STAGES-1];
    end
  end

  assign level = sr[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave to register-bus bridge, fully oversampled on CLK.
// Decodes cmd/addr/data frames; single and auto-increment burst access.
module spi_reg_bridge
  import spi_bridge_defs::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             spi_cs,
  input  logic             spi_sck,
  input  logic             spi_mosi,
  output logic             spi_miso,
  spi_reg_bridge_if.master reg_bus,
  output logic             busy,
  output logic             frame_abort
);

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

  state_t state_q, state_d;

  logic cs_q, cs_rise, cs_fall;
  logic sck_q, sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic mosi_q;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sr, rx_next, tx_sr;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] addr_q, addr_inc, ra_q;
  logic wr_q, burst_q, first_q, miso_q;
  logic ce_q, we_q, rd_pend, abort_q;
  logic shift_en, cmd_done, addr_done, word_done, abort;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .CLK   (CLK),
    .rst   (rst),
    .pin   (spi_cs),
    .level (cs_q),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .CLK   (CLK),
    .rst   (rst),
    .pin   (spi_sck),
    .level (sck_q),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  always_ff @(posedge CLK) begin
    if (rst) mosi_sr <= '0;
    else     mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
  end

  assign mosi_q   = mosi_sr[SYNC_STAGES-1];
  assign rx_next  = {rx_sr[DATA_W-2:0], mosi_q};
  assign addr_inc = addr_q + ADDR_W'(1);

  always_ff @(posedge CLK) begin
    if (rst) state_q <= ST_WAIT_CS;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_done  = 1'b0;
    addr_done = 1'b0;
    word_done = 1'b0;
    abort     = 1'b0;
    shift_en  = sck_rise && in_frame(state_q) && !cs_rise;
    unique case (state_q)
      ST_WAIT_CS: if (cs_q) state_d = ST_IDLE;
      // mode 0: a frame only starts with SCK idling low
      ST_IDLE:    if (cs_fall && !sck_q) state_d = ST_CMD;
      ST_CMD: begin
        if (shift_en && bit_cnt == CMD_LAST) begin
          cmd_done = 1'b1;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (shift_en && bit_cnt == ADDR_LAST) begin
          addr_done = 1'b1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (shift_en && bit_cnt == WORD_LAST) word_done = 1'b1;
      end
      default: state_d = ST_WAIT_CS;
    endcase
    if (cs_rise) begin
      state_d = ST_IDLE;
      abort   = (state_q == ST_DATA) && (bit_cnt != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      ra_q    <= '0;
      wr_q    <= 1'b0;
      burst_q <= 1'b0;
      first_q <= 1'b0;
      miso_q  <= 1'b0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      rd_pend <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      rd_pend <= ce_q & ~we_q;
      abort_q <= abort;
      if (shift_en) begin
        rx_sr   <= rx_next;
        bit_cnt <= (cmd_done | addr_done | word_done) ?
                   '0 : bit_cnt + CNT_W'(1);
      end
      if (sck_fall && !cs_rise) begin
        if (state_q == ST_DATA) begin
          miso_q <= tx_sr[DATA_W-1];
          tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end
      if (rd_pend) tx_sr <= reg_bus.reg_rdata;
      if (cmd_done) begin
        wr_q    <= rx_next[CMD_WR_BIT];
        burst_q <= rx_next[CMD_BURST_BIT];
      end
      if (addr_done) begin
        addr_q  <= rx_next[ADDR_W-1:0];
        first_q <= 1'b1;
        if (!wr_q) begin
          ce_q <= 1'b1;
          ra_q <= rx_next[ADDR_W-1:0];
        end
      end
      if (word_done) begin
        first_q <= 1'b0;
        if (burst_q) addr_q <= addr_inc;
        if (wr_q && (first_q || burst_q)) begin
          ce_q    <= 1'b1;
          we_q    <= 1'b1;
          ra_q    <= addr_q;
          wdata_q <= rx_next;
        end
        // read burst prefetches so data is ready before the next fall
        if (!wr_q && burst_q) begin
          ce_q <= 1'b1;
          ra_q <= addr_inc;
        end
      end
      if (state_q == ST_IDLE) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
        tx_sr   <= '0;
        miso_q  <= 1'b0;
        wr_q    <= 1'b0;
        burst_q <= 1'b0;
        first_q <= 1'b0;
      end
    end
  end

  assign reg_bus.reg_ce    = ce_q;
  assign reg_bus.reg_we    = we_q;
  assign reg_bus.reg_addr  = ra_q;
  assign reg_bus.reg_wdata = wdata_q;
  assign spi_miso          = miso_q;
  assign busy              = in_frame(state_q);
  assign frame_abort       = abort_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: SPI master model plus register model.
// Each comparison is an immediate assertion; counts feed the summary.
module tb_spi_reg_bridge;

  logic CLK      = 1'b0;
  logic rst      = 1'b1;
  logic spi_cs   = 1'b1;
  logic spi_sck  = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_miso, busy, frame_abort;

  int checks = 0, errors = 0, cyc = 0;
  int n_acc = 0, n_abort = 0, last_rise = 0;
  int base, ab0, rise_ref;
  logic [7:0]  acc_addr [64];
  logic [15:0] acc_wdata[64];
  logic        acc_we   [64];
  int          acc_cyc  [64];
  logic [15:0] mem[256];
  logic [63:0] rx;

  spi_reg_bridge_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  spi_reg_bridge #(
    .ADDR_W      (8),
    .DATA_W      (16),
    .SYNC_STAGES (2)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .spi_cs      (spi_cs),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .reg_bus     (bus),
    .busy        (busy),
    .frame_abort (frame_abort)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // read data valid only the cycle after a read strobe
  always @(posedge CLK)
    bus.reg_rdata <= (bus.reg_ce && !bus.reg_we) ?
                     mem[bus.reg_addr] : 16'hDEAD;

  always @(negedge CLK) begin
    if (bus.reg_ce && n_acc < 64) begin
      acc_addr[n_acc]  = bus.reg_addr;
      acc_wdata[n_acc] = bus.reg_wdata;
      acc_we[n_acc]    = bus.reg_we;
      acc_cyc[n_acc]   = cyc;
      n_acc            = n_acc + 1;
    end
    if (frame_abort) n_abort = n_abort + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, input int half, output logic s);
    spi_mosi = b;
    repeat (half) @(negedge CLK);
    s = spi_miso;
    spi_sck   = 1'b1;
    last_rise = cyc;
    repeat (half) @(negedge CLK);
    spi_sck = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] tx, input int nbits,
                           input int half);
    logic s;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bit(tx[i], half, s);
      rx = {rx[62:0], s};
    end
  endtask

  task automatic cs_drop();
    @(negedge CLK);
    spi_cs = 1'b0;
    rx     = '0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic cs_raise();
    repeat (4) @(negedge CLK);
    spi_cs = 1'b1;
    repeat (8) @(negedge CLK);
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.reg_ce, bus.reg_we, bus.reg_addr, bus.reg_wdata,
                spi_miso, busy, frame_abort});
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 | 16'(i);
    mem[8'h34] = 16'hA5C3;
    mem[8'h10] = 16'h1234;
    mem[8'h11] = 16'hCAFE;
    mem[8'h12] = 16'h0F0F;

    repeat (4) @(negedge CLK);
    chk("reset_outputs", outs(), 64'h0);
    rst = 1'b0;
    repeat (6) @(negedge CLK);

    // single write
    base = n_acc;
    cs_drop();
    chk("busy_in_frame", 64'(busy), 64'h1);
    send_bits(64'h8012_BEEF, 32, 5);
    rise_ref = last_rise;
    cs_raise();
    chk("wr_count", 64'(n_acc - base), 64'd1);
    chk("wr_we", 64'(acc_we[base]), 64'h1);
    chk("wr_addr", 64'(acc_addr[base]), 64'h12);
    chk("wr_data", 64'(acc_wdata[base]), 64'hBEEF);
    chk("wr_latency", 64'(acc_cyc[base] - rise_ref), 64'd3);
    chk("busy_after", 64'(busy), 64'h0);

    // single read
    base = n_acc;
    cs_drop();
    send_bits(64'h0034_0000, 32, 5);
    cs_raise();
    chk("rd_count", 64'(n_acc - base), 64'd1);
    chk("rd_we", 64'(acc_we[base]), 64'h0);
    chk("rd_addr", 64'(acc_addr[base]), 64'h34);
    chk("rd_miso_data", 64'(rx[15:0]), 64'hA5C3);
    chk("rd_miso_hdr", 64'(rx[31:16]), 64'h0);

    // burst write wrapping 0xFF -> 0x00
    base = n_acc;
    cs_drop();
    send_bits(64'hC0FE_1111_2222_3333, 64, 5);
    cs_raise();
    chk("bw_count", 64'(n_acc - base), 64'd3);
    chk("bw_addrs", 64'({acc_addr[base], acc_addr[base+1],
                         acc_addr[base+2]}), 64'hFEFF00);
    chk("bw_data", 64'({acc_wdata[base], acc_wdata[base+1],
                        acc_wdata[base+2]}), 64'h1111_2222_3333);
    chk("bw_we", 64'({acc_we[base], acc_we[base+1], acc_we[base+2]}),
        64'h7);

    // burst read
    base = n_acc;
    cs_drop();
    send_bits(64'h4010_0000_0000_0000, 64, 5);
    cs_raise();
    chk("br_addrs", 64'({acc_addr[base], acc_addr[base+1],
                         acc_addr[base+2]}), 64'h101112);
    chk("br_we", 64'({acc_we[base], acc_we[base+1], acc_we[base+2]}),
        64'h0);
    chk("br_miso", 64'(rx[47:0]), 64'h1234_CAFE_0F0F);

    // CS rises after 23 bits: partial word
    base = n_acc;
    ab0  = n_abort;
    cs_drop();
    send_bits(64'(32'h8055_ABCD >> 9), 23, 5);
    cs_raise();
    chk("ab_no_access", 64'(n_acc - base), 64'd0);
    chk("ab_pulse", 64'(n_abort - ab0), 64'd1);
    chk("ab_busy", 64'(busy), 64'h0);
    base = n_acc;
    cs_drop();
    send_bits(64'h8021_1357, 32, 5);
    cs_raise();
    chk("ab_next_count", 64'(n_acc - base), 64'd1);
    chk("ab_next_addr", 64'(acc_addr[base]), 64'h21);
    chk("ab_next_data", 64'(acc_wdata[base]), 64'h1357);

    // reset at data bit 20 with CS low
    base = n_acc;
    ab0  = n_abort;
    cs_drop();
    send_bits(64'(32'h8066_4321 >> 12), 20, 5);
    rst = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_mid_outputs", outs(), 64'h0);
    @(negedge CLK);
    rst = 1'b0;
    send_bits(64'h321, 12, 5);
    chk("rst_mid_busy", 64'(busy), 64'h0);
    cs_raise();
    chk("rst_no_access", 64'(n_acc - base), 64'd0);
    chk("rst_no_abort", 64'(n_abort - ab0), 64'd0);
    base = n_acc;
    cs_drop();
    send_bits(64'h8077_A1B2, 32, 5);
    cs_raise();
    chk("rst_next_count", 64'(n_acc - base), 64'd1);
    chk("rst_next_addr", 64'(acc_addr[base]), 64'h77);
    chk("rst_next_data", 64'(acc_wdata[base]), 64'hA1B2);

    // minimum SCK phase of 4 CLK
    base = n_acc;
    cs_drop();
    send_bits(64'h0034_0000, 32, 4);
    cs_raise();
    chk("min_rd_first_bit", 64'(rx[15]), 64'h1);
    chk("min_rd_data", 64'(rx[15:0]), 64'hA5C3);
    cs_drop();
    send_bits(64'h4010_0000_0000_0000, 64, 4);
    cs_raise();
    chk("min_br_miso", 64'(rx[47:0]), 64'h1234_CAFE_0F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
